// File: rtl/decode_execute_pipe.sv
// decode_execute_pipe: decode->execute pipeline register for the RV32IM core.
// Valid/ready handshake backed by an output register plus one skid entry, so
// in_ready comes straight from a flop. Also produces out_div_start, which is
// cleared for the second op of a div/rem pair that reuses the same operands.
module decode_execute_pipe #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic [XLEN-1:0]   in_rd1,
  input  logic [XLEN-1:0]   in_rd2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_regwr,
  input  logic              in_div,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pc4,
  output logic [XLEN-1:0]   out_rd1,
  output logic [XLEN-1:0]   out_rd2,
  output logic [XLEN-1:0]   out_imm,
  output logic [RA_W-1:0]   out_rs1,
  output logic [RA_W-1:0]   out_rs2,
  output logic [RA_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_regwr,
  output logic              out_div_start
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
    logic              regwr;
    logic              div_start;
  } entry_t;

  entry_t          in_ent, out_q, skid_q;
  logic            out_vld, skid_full;
  logic            enq, load_out;
  logic            rec_v, rec_hit, wb_kill, wr_kill;
  logic [RA_W-1:0] rec_rs1, rec_rs2;

  // With a skid entry, ready is purely registered; without it, ready must
  // look through to out_ready.
  assign in_ready = (SKID != 0) ? !skid_full : (out_ready | !out_vld);
  assign enq      = in_valid & in_ready;
  assign load_out = !out_vld | out_ready;

  // Record lookup uses the record as it stands before this edge's update.
  assign rec_hit = rec_v & (in_rs1 == rec_rs1) & (in_rs2 == rec_rs2);
  assign wb_kill = wb_we & (wb_rd != '0) & ((wb_rd == rec_rs1) | (wb_rd == rec_rs2));
  assign wr_kill = enq & !in_div & in_regwr & (in_rd != '0) &
                   ((in_rd == rec_rs1) | (in_rd == rec_rs2));

  // Pack the incoming op together with its divider start decision.
  always_comb begin
    in_ent           = '0;
    in_ent.pc        = in_pc;
    in_ent.pc4       = in_pc4;
    in_ent.rd1       = in_rd1;
    in_ent.rd2       = in_rd2;
    in_ent.imm       = in_imm;
    in_ent.rs1       = in_rs1;
    in_ent.rs2       = in_rs2;
    in_ent.rd        = in_rd;
    in_ent.ctrl      = in_ctrl;
    in_ent.regwr     = in_regwr;
    in_ent.div_start = in_div & !rec_hit;
  end

  // Occupancy: output register first, skid only while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      skid_full <= 1'b0;
    end else if (flush) begin
      out_vld   <= 1'b0;
      skid_full <= 1'b0;
    end else if (load_out) begin
      if (skid_full) begin
        out_vld   <= 1'b1;
        skid_full <= 1'b0;
      end else begin
        out_vld   <= enq;
      end
    end else if (enq && (SKID != 0)) begin
      skid_full <= 1'b1;
    end
  end

  // Payload moves only with the occupancy above; flush leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (load_out) begin
        if (skid_full)  out_q <= skid_q;
        else if (enq)   out_q <= in_ent;
      end else if (enq) begin
        skid_q <= in_ent;
      end
    end
  end

  // Operand record of the last div/rem; a div enqueue rewrites it, any
  // overwrite of a recorded source register invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_v   <= 1'b0;
      rec_rs1 <= '0;
      rec_rs2 <= '0;
    end else if (flush) begin
      rec_v   <= 1'b0;
    end else if (enq && in_div) begin
      rec_v   <= ((in_rd != in_rs1) && (in_rd != in_rs2)) || !in_regwr;
      rec_rs1 <= in_rs1;
      rec_rs2 <= in_rs2;
    end else if (wb_kill || wr_kill) begin
      rec_v   <= 1'b0;
    end
  end

  assign out_valid     = out_vld;
  assign out_pc        = out_q.pc;
  assign out_pc4       = out_q.pc4;
  assign out_rd1       = out_q.rd1;
  assign out_rd2       = out_q.rd2;
  assign out_imm       = out_q.imm;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_ctrl      = out_q.ctrl;
  assign out_regwr     = out_q.regwr;
  assign out_div_start = out_q.div_start;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Scoreboard bench for decode_execute_pipe: one SKID=1 and one SKID=0 instance.
// Stimulus pushes expected entries on handshake; monitors pop on output transfer.
module tb_decode_execute_pipe;

  typedef struct packed {
    logic [31:0] pc, pc4, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ctrl;
    logic        regwr, div_start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0] vld = 2'b00;
  logic [1:0] rdy;
  logic [31:0] in_pc = '0, in_pc4 = '0, in_rd1 = '0, in_rd2 = '0, in_imm = '0, in_ctrl = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_rd = '0;
  logic in_regwr = 1'b0, in_div = 1'b0, wb_we = 1'b0;
  logic out_ready0 = 1'b1, out_ready1 = 1'b1;

  logic        out_valid0, out_valid1, in_ready0, in_ready1;
  logic [31:0] out_pc0, out_pc40, out_rd10, out_rd20, out_imm0, out_ctrl0;
  logic [31:0] out_pc1, out_pc41, out_rd11, out_rd21, out_imm1, out_ctrl1;
  logic [4:0]  out_rs10, out_rs20, out_rd0, out_rs11, out_rs21, out_rd1;
  logic        out_regwr0, out_ds0, out_regwr1, out_ds1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t got0, got1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign rdy = {in_ready1, in_ready0};

  decode_execute_pipe #(.XLEN(32), .RA_W(5), .CTRL_W(32), .SKID(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(vld[0]), .in_ready(in_ready0),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .in_regwr(in_regwr), .in_div(in_div), .wb_we(wb_we), .wb_rd(wb_rd),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_pc(out_pc0), .out_pc4(out_pc40), .out_rd1(out_rd10), .out_rd2(out_rd20),
    .out_imm(out_imm0), .out_rs1(out_rs10), .out_rs2(out_rs20), .out_rd(out_rd0),
    .out_ctrl(out_ctrl0), .out_regwr(out_regwr0), .out_div_start(out_ds0));

  decode_execute_pipe #(.XLEN(32), .RA_W(5), .CTRL_W(32), .SKID(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(vld[1]), .in_ready(in_ready1),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .in_regwr(in_regwr), .in_div(in_div), .wb_we(wb_we), .wb_rd(wb_rd),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_pc(out_pc1), .out_pc4(out_pc41), .out_rd1(out_rd11), .out_rd2(out_rd21),
    .out_imm(out_imm1), .out_rs1(out_rs11), .out_rs2(out_rs21), .out_rd(out_rd1),
    .out_ctrl(out_ctrl1), .out_regwr(out_regwr1), .out_div_start(out_ds1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    got0 = {out_pc0, out_pc40, out_rd10, out_rd20, out_imm0, out_rs10, out_rs20, out_rd0,
            out_ctrl0, out_regwr0, out_ds0};
    got1 = {out_pc1, out_pc41, out_rd11, out_rd21, out_imm1, out_rs11, out_rs21, out_rd1,
            out_ctrl1, out_regwr1, out_ds1};
  end

  // Monitor, SKID=1 instance: head must be presented (and held) until taken.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL out0_unexpected actual_pc=%0h required=none", out_pc0);
      end else begin
        if (got0 !== q0[0]) begin
          failures++;
          $display("FAIL out0_entry actual=%h required=%h", got0, q0[0]);
        end
        if (out_ready0) void'(q0.pop_front());
      end
    end
  end

  // Monitor, SKID=0 instance.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL out1_unexpected actual_pc=%0h required=none", out_pc1);
      end else begin
        if (got1 !== q1[0]) begin
          failures++;
          $display("FAIL out1_entry actual=%h required=%h", got1, q1[0]);
        end
        if (out_ready1) void'(q1.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                              input logic regwr, ds);
    exp_t e;
    e.pc = pc; e.pc4 = pc + 32'd4;
    e.rd1 = pc ^ 32'h1111_0000; e.rd2 = pc ^ 32'h2222_0000;
    e.imm = pc ^ 32'h0000_0ff0; e.ctrl = ~pc;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.regwr = regwr; e.div_start = ds;
    return e;
  endfunction

  task automatic drive_in(input exp_t e, input logic div);
    in_pc = e.pc; in_pc4 = e.pc4; in_rd1 = e.rd1; in_rd2 = e.rd2; in_imm = e.imm;
    in_ctrl = e.ctrl; in_rs1 = e.rs1; in_rs2 = e.rs2; in_rd = e.rd;
    in_regwr = e.regwr; in_div = div;
  endtask

  // Called and returns at posedge+1. ds is the hand-computed out_div_start.
  task automatic send(input int w, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                      input logic regwr, div, ds);
    exp_t e;
    bit done;
    e = mk(pc, rs1, rs2, rd, regwr, ds);
    drive_in(e, div);
    vld[w] = 1'b1;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      #2;
      if (rdy[w] && !flush) begin
        if (w == 0) q0.push_back(e); else q1.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    vld[w] = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted pc=%0h", pc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_pc", out_pc0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready0, 1);
    chk("rst_in_ready_s0", in_ready1, 1);
    @(posedge clk); #1;

    // Streaming, 1-cycle latency
    out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(0, 32'(i * 4), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("lat_valid", out_valid0, 1);
      chk("lat_pc", out_pc0, 64'(i * 4));
    end
    idle(2);

    // Backpressure for 3 cycles
    send(0, 32'h40, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    out_ready0 = 1'b0;
    fork
      begin
        @(posedge clk); #2;
        chk("bp_in_ready", in_ready0, 0);
        @(posedge clk); @(posedge clk); #1;
        out_ready0 = 1'b1;
      end
      begin
        send(0, 32'h44, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        send(0, 32'h48, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        send(0, 32'h4c, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      end
    join
    idle(3);

    // Flush with output + skid full and input valid
    out_ready0 = 1'b0;
    send(0, 32'h100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    send(0, 32'h104, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("fl_pre_in_ready", in_ready0, 0);
    drive_in(mk(32'h108, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0);
    vld[0] = 1'b1; flush = 1'b1;
    #2 q0.delete();
    @(posedge clk); #1;
    flush = 1'b0; vld[0] = 1'b0;
    chk("fl_out_valid", out_valid0, 0);
    chk("fl_in_ready", in_ready0, 1);
    out_ready0 = 1'b1;
    send(0, 32'h10c, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Divider start: plain pair, pair split by writeback, self-overwriting div
    send(0, 32'h200, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
    send(0, 32'h204, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
    send(0, 32'h208, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd3;
    idle(1);
    wb_we = 1'b0; wb_rd = 5'd0;
    send(0, 32'h20c, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1);
    send(0, 32'h210, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1);
    send(0, 32'h214, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1);
    // non-div write of x1 invalidates the record just built by the rem
    send(0, 32'h218, 5'd7, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
    send(0, 32'h21c, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1);
    send(0, 32'h220, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
    idle(2);

    // SKID=0: full throughput and combinational ready
    out_ready1 = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      send(1, 32'h300 + 32'(i * 4), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("s0_tput_cycles", 64'(cyc - t0), 4);
    out_ready1 = 1'b0;
    #1 chk("s0_ready_low", in_ready1, 0);
    out_ready1 = 1'b1;
    #1 chk("s0_ready_high", in_ready1, 1);
    @(posedge clk); #1;
    idle(1);

    // Reset mid-stream
    out_ready0 = 1'b0;
    send(0, 32'h400, 5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
    chk("mid_pre_valid", out_valid0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid0, 0);
    chk("mid_out_pc", {out_pc0, out_pc40}, 0);
    chk("mid_out_rd", {out_rd10, out_rd20}, 0);
    chk("mid_out_imm_ctrl", {out_imm0, out_ctrl0}, 0);
    chk("mid_out_idx", {out_rs10, out_rs20, out_rd0, out_regwr0, out_ds0}, 0);
    q0.delete(); q1.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("mid_in_ready", in_ready0, 1);
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    send(0, 32'h500, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Drain
    for (int k = 0; k < 50 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    #1 chk("drain_q", 64'(q0.size() + q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
